// File: rtl/frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : frame_buffer
// Purpose  : Double-buffered 16-bit pixel store. It packs host bytes into words
//            and swaps banks only on the matrix driver's frame-sync pulse.
//            Define FRAMEBUF_DUAL_PANEL_EN to enable panel 2 and 1024-byte frames.
// Revision : 1.0  initial release
// ============================================================================
module frame_buffer #(
  parameter int DEPTH = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_valid,
  input  logic [7:0]  i_wr_data,
  input  logic        i_wr_start,
  output logic        o_wr_ready,
  output logic        o_frame_done,
  input  logic        i_frame_sync,
  output logic        o_swapped,
  input  logic [7:0]  i_raddr_1,
  input  logic [7:0]  i_raddr_2,
  output logic [15:0] o_rdata_1,
  output logic [15:0] o_rdata_2
);

`ifdef FRAMEBUF_DUAL_PANEL_EN
  localparam logic [9:0] C_LAST = 10'd1023;
`else
  localparam logic [9:0] C_LAST = 10'd511;
`endif

  logic        r_front;
  logic        r_pending;
  logic        r_front_valid;
  logic        r_frame_done;
  logic        r_swapped;
  logic        r_rd_en;
  logic [9:0]  r_wcnt;
  logic [7:0]  r_stage;

  logic        w_accept;
  logic        w_last;
  logic        w_we;
  logic        w_we_1;
  logic        w_swap;
  logic [9:0]  w_cnt;
  logic [8:0]  w_waddr;
  logic [15:0] w_wdata;

  assign o_wr_ready   = ~r_pending;
  assign o_frame_done = r_frame_done;
  assign o_swapped    = r_swapped;

  // A start byte overrides the running count, abandoning any partial frame.
  assign w_accept = i_wr_valid & ~r_pending;
  assign w_cnt    = i_wr_start ? 10'd0 : r_wcnt;
  assign w_last   = (w_cnt == C_LAST);
  assign w_we     = w_accept & w_cnt[0];
  assign w_waddr  = {~r_front, w_cnt[8:1]};
  assign w_wdata  = {i_wr_data, r_stage};
  assign w_swap   = i_frame_sync & r_pending;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_front       <= 1'b0;
      r_pending     <= 1'b0;
      r_front_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_swapped     <= 1'b0;
      r_rd_en       <= 1'b0;
      r_wcnt        <= 10'd0;
      r_stage       <= 8'd0;
    end else begin
      r_frame_done <= w_accept & w_last;
      r_swapped    <= w_swap;
      r_rd_en      <= r_front_valid;
      if (w_accept) begin
        if (!w_cnt[0]) begin
          r_stage <= i_wr_data;
        end
        if (w_last) begin
          r_wcnt    <= 10'd0;
          r_pending <= 1'b1;
        end else begin
          r_wcnt <= w_cnt + 10'd1;
        end
      end
      // Swap and pending-set are exclusive: one needs r_pending high, the other low.
      if (w_swap) begin
        r_front       <= ~r_front;
        r_pending     <= 1'b0;
        r_front_valid <= 1'b1;
      end
    end
  end

  // Panel 1: both banks in one array, bank select in the address MSB.
  logic [15:0] r_mem_1 [0:2*DEPTH-1];
  logic [15:0] r_ram_1;

`ifdef FRAMEBUF_DUAL_PANEL_EN
  assign w_we_1 = w_we & ~w_cnt[9];
`else
  assign w_we_1 = w_we;
`endif

  always_ff @(posedge i_clk) begin
    if (w_we_1) begin
      r_mem_1[w_waddr] <= w_wdata;
    end
    r_ram_1 <= r_mem_1[{r_front, i_raddr_1}];
  end

  assign o_rdata_1 = r_rd_en ? r_ram_1 : 16'h0000;

`ifdef FRAMEBUF_DUAL_PANEL_EN
  logic [15:0] r_mem_2 [0:2*DEPTH-1];
  logic [15:0] r_ram_2;
  logic        w_we_2;

  assign w_we_2 = w_we & w_cnt[9];

  always_ff @(posedge i_clk) begin
    if (w_we_2) begin
      r_mem_2[w_waddr] <= w_wdata;
    end
    r_ram_2 <= r_mem_2[{r_front, i_raddr_2}];
  end

  assign o_rdata_2 = r_rd_en ? r_ram_2 : 16'h0000;
`else
  logic w_unused;
  assign w_unused  = ^i_raddr_2;
  assign o_rdata_2 = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer.sv
`default_nettype none
// Scoreboard bench for frame_buffer: stimulus pushes expected reads and pulse
// cycles into queues, a negedge monitor pops and compares them.
module tb_frame_buffer;

`ifdef FRAMEBUF_DUAL_PANEL_EN
  localparam int FRAME = 1024;
  localparam bit DUAL  = 1'b1;
`else
  localparam int FRAME = 512;
  localparam bit DUAL  = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_wr_valid = 1'b0;
  logic [7:0]  i_wr_data = 8'd0;
  logic        i_wr_start = 1'b0;
  logic        o_wr_ready;
  logic        o_frame_done;
  logic        i_frame_sync = 1'b0;
  logic        o_swapped;
  logic [7:0]  i_raddr_1 = 8'd0;
  logic [7:0]  i_raddr_2 = 8'd0;
  logic [15:0] o_rdata_1;
  logic [15:0] o_rdata_2;

  frame_buffer #(.DEPTH(256)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .i_wr_start(i_wr_start),
    .o_wr_ready(o_wr_ready), .o_frame_done(o_frame_done),
    .i_frame_sync(i_frame_sync), .o_swapped(o_swapped),
    .i_raddr_1(i_raddr_1), .i_raddr_2(i_raddr_2),
    .o_rdata_1(o_rdata_1), .o_rdata_2(o_rdata_2)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       nm;
    logic [15:0] e1;
    logic [15:0] e2;
  } rd_t;

  rd_t rd_q[$];
  int  done_q[$];
  int  swap_q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  logic rd_req = 1'b0;
  logic rd_pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(posedge i_clk) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_req;
  end

  // Monitor: reads and pulses are compared against the queued expectations.
  always @(negedge i_clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        chk("read without expectation", 32'd1, 32'd0);
      end else begin
        rd_t e;
        e = rd_q.pop_front();
        chk({e.nm, " port1"}, {16'd0, o_rdata_1}, {16'd0, e.e1});
        chk({e.nm, " port2"}, {16'd0, o_rdata_2}, {16'd0, e.e2});
      end
    end
    if (o_frame_done) begin
      if (done_q.size() == 0) chk("unexpected frame_done", 32'd1, 32'd0);
      else chk("frame_done cycle", cyc, done_q.pop_front());
    end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
      chk("missing frame_done", 32'd0, 32'd1);
      void'(done_q.pop_front());
    end
    if (o_swapped) begin
      if (swap_q.size() == 0) chk("unexpected swapped", 32'd1, 32'd0);
      else chk("swapped cycle", cyc, swap_q.pop_front());
    end else if (swap_q.size() > 0 && swap_q[0] <= cyc) begin
      chk("missing swapped", 32'd0, 32'd1);
      void'(swap_q.pop_front());
    end
  end

  // One clock of stimulus; all inputs default low unless requested.
  task automatic step(input bit v, input logic [7:0] d, input bit s, input bit fs,
                      input bit exp_done, input bit exp_swap,
                      input bit rd, input logic [7:0] a1, input logic [7:0] a2,
                      input string nm, input logic [15:0] e1, input logic [15:0] e2);
    @(negedge i_clk);
    i_wr_valid   = v;
    i_wr_data    = d;
    i_wr_start   = s;
    i_frame_sync = fs;
    rd_req       = rd;
    i_raddr_1    = a1;
    i_raddr_2    = a2;
    if (exp_done) done_q.push_back(cyc + 1);
    if (exp_swap) swap_q.push_back(cyc + 1);
    if (rd) rd_q.push_back('{nm, e1, e2});
  endtask

  task automatic idle();
    step(0, 8'd0, 0, 0, 0, 0, 0, 8'd0, 8'd0, "", 16'd0, 16'd0);
  endtask

  task automatic rd(input logic [7:0] a1, input logic [7:0] a2, input string nm,
                    input logic [15:0] e1, input logic [15:0] e2);
    step(0, 8'd0, 0, 0, 0, 0, 1, a1, a2, nm, e1, e2);
  endtask

  task automatic sync(input bit exp_swap);
    step(0, 8'd0, 0, 1, 0, exp_swap, 0, 8'd0, 8'd0, "", 16'd0, 16'd0);
  endtask

  // Full frame of byte k = k[7:0] ^ xv, optionally with sync on the last byte.
  task automatic write_frame(input logic [7:0] xv, input bit sync_last);
    for (int k = 0; k < FRAME; k++) begin
      step(1, 8'(k) ^ xv, k == 0, sync_last && (k == FRAME - 1), k == FRAME - 1, 0,
           0, 8'd0, 8'd0, "", 16'd0, 16'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge i_clk);
    chk("reset wr_ready", {31'd0, o_wr_ready}, 32'd1);
    chk("reset frame_done", {31'd0, o_frame_done}, 32'd0);
    chk("reset swapped", {31'd0, o_swapped}, 32'd0);
    chk("reset rdata_1", {16'd0, o_rdata_1}, 32'd0);
    i_rst_n = 1'b1;

    // Blank before first frame
    rd(8'd0, 8'd0, "blank a0", 16'h0000, 16'h0000);
    rd(8'd5, 8'd200, "blank a5", 16'h0000, 16'h0000);
    idle();

    // Fill and swap
    write_frame(8'h00, 0);
    idle();
    chk("wr_ready after last byte", {31'd0, o_wr_ready}, 32'd0);
    rd(8'd3, 8'd0, "pre-sync blank", 16'h0000, 16'h0000);
    step(0, 8'd0, 0, 1, 0, 1, 1, 8'd3, 8'd0, "read in first sync cycle", 16'h0000, 16'h0000);
    rd(8'd3, 8'd0, "fill a3", 16'h0706, DUAL ? 16'h0100 : 16'h0000);
    chk("wr_ready after swap", {31'd0, o_wr_ready}, 32'd1);
    rd(8'd0, 8'd0, "fill a0", 16'h0100, DUAL ? 16'h0100 : 16'h0000);

    // Tear-free swap: frame B = k ^ 0xFF
    write_frame(8'hFF, 0);
    idle();
    rd(8'd3, 8'd0, "B pending shows A", 16'h0706, DUAL ? 16'h0100 : 16'h0000);
    step(0, 8'd0, 0, 1, 0, 1, 1, 8'd3, 8'd0, "sync-cycle shows A", 16'h0706,
         DUAL ? 16'h0100 : 16'h0000);
    rd(8'd3, 8'd0, "post-sync shows B", 16'hF8F9, DUAL ? 16'hFEFF : 16'h0000);

    // Restart mid-frame after 300 bytes
    for (int k = 0; k < 300; k++)
      step(1, 8'h55, k == 0, 0, 0, 0, 0, 8'd0, 8'd0, "", 16'd0, 16'd0);
    step(1, 8'hAA, 1, 0, 0, 0, 0, 8'd0, 8'd0, "", 16'd0, 16'd0);
    for (int k = 1; k < FRAME; k++)
      step(1, 8'(k), 0, 0, k == FRAME - 1, 0, 0, 8'd0, 8'd0, "", 16'd0, 16'd0);
    idle();
    sync(1);
    rd(8'd0, 8'd0, "restart a0", 16'h01AA, DUAL ? 16'h0100 : 16'h0000);
    rd(8'd3, 8'd0, "restart a3", 16'h0706, DUAL ? 16'h0100 : 16'h0000);

    // Sync without pending has no effect
    sync(0);
    idle();
    rd(8'd0, 8'd0, "no-pending sync", 16'h01AA, DUAL ? 16'h0100 : 16'h0000);

    // Sync coinciding with last byte is not honoured; next sync swaps
    write_frame(8'h0F, 1);
    idle();
    idle();
    chk("wr_ready still pending", {31'd0, o_wr_ready}, 32'd0);
    rd(8'd0, 8'd0, "coincident sync no swap", 16'h01AA, DUAL ? 16'h0100 : 16'h0000);
    sync(1);
    rd(8'd3, 8'd0, "late swap frame C", 16'h0809, DUAL ? 16'h0E0F : 16'h0000);

    // Async reset mid-write while a read is presenting data
    for (int k = 0; k < 100; k++)
      step(1, 8'h33, k == 0, 0, 0, 0, k == 99, 8'd3, 8'd0, "pre-reset read",
           16'h0809, DUAL ? 16'h0E0F : 16'h0000);
    step(1, 8'h33, 0, 0, 0, 0, 0, 8'd3, 8'd0, "", 16'd0, 16'd0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async rst rdata_1", {16'd0, o_rdata_1}, 32'd0);
    chk("async rst rdata_2", {16'd0, o_rdata_2}, 32'd0);
    chk("async rst wr_ready", {31'd0, o_wr_ready}, 32'd1);
    chk("async rst frame_done", {31'd0, o_frame_done}, 32'd0);
    idle();
    idle();
    i_rst_n = 1'b1;
    rd(8'd3, 8'd0, "post-reset dark", 16'h0000, 16'h0000);
    write_frame(8'h00, 0);
    idle();
    rd(8'd3, 8'd0, "post-reset pending dark", 16'h0000, 16'h0000);
    sync(1);
    rd(8'd3, 8'd0, "post-reset new frame", 16'h0706, DUAL ? 16'h0100 : 16'h0000);
    idle();
    idle();
    idle();

    chk("read queue drained", rd_q.size(), 32'd0);
    chk("done queue drained", done_q.size(), 32'd0);
    chk("swap queue drained", swap_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
